// File: rtl/mem_access_arbiter.sv
// Two-requester memory access arbiter: a fetch port (32-bit reads only) and a
// data port (8/16/32-bit reads and writes) share one memory port. Ties are
// broken round-robin, misaligned or invalid-size accesses are refused without
// touching memory, and a stuck memory is abandoned after TIMEOUT_CYCLES cycles.
//
// Handshake: a requester holds req and its fields stable until its one-cycle
// ack pulse and drops or replaces req in the cycle after ack. err and rdata are
// valid only with ack; rdata holds its last value otherwise. On the memory side
// mem_req stays high until mem_ack or timeout. mem_ack is only honoured while
// the arbiter is waiting on memory.
module mem_access_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_ack,
  output logic        f_err,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_type,
  input  logic [1:0]  d_size,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_type,
  output logic [1:0]  mem_size,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // Count value at which one more stalled WAIT cycle reaches the limit.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_n;
  logic          gnt_d, gnt_d_n;      // current grant belongs to the data port
  logic          last_d, last_d_n;    // last grant went to the data port
  logic [CW-1:0] cnt, cnt_n;
  logic          err_q, err_n;
  logic          mem_req_n;
  logic [31:0]   mem_addr_n, mem_wdata_n;
  logic          mem_type_n;
  logic [1:0]    mem_size_n;
  logic [31:0]   f_rdata_n, d_rdata_n;

  // Grant selection scratch values
  logic          pick_d;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic          sel_type;
  logic [1:0]    sel_size;
  logic [31:0]   rd_val;

  // Size 1 needs halfword alignment, size 2 word alignment, size 3 is invalid.
  function automatic logic is_bad(input logic [1:0] sz, input logic [1:0] a);
    logic bad;
    case (sz)
      2'd0:    bad = 1'b0;
      2'd1:    bad = a[0];
      2'd2:    bad = (a != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Memory data is right-justified; keep only the accessed bytes.
  function automatic logic [31:0] mask_rd(input logic [1:0] sz, input logic [31:0] v);
    logic [31:0] r;
    case (sz)
      2'd0:    r = {24'd0, v[7:0]};
      2'd1:    r = {16'd0, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  assign dbg_state = state;
  assign f_ack     = (state == DONE) && !gnt_d;
  assign d_ack     = (state == DONE) && gnt_d;
  assign f_err     = f_ack && err_q;
  assign d_err     = d_ack && err_q;

  // Next-state and next-register values for the arbiter FSM.
  always_comb begin
    state_n     = state;
    gnt_d_n     = gnt_d;
    last_d_n    = last_d;
    cnt_n       = cnt;
    err_n       = err_q;
    mem_req_n   = mem_req;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    mem_type_n  = mem_type;
    mem_size_n  = mem_size;
    f_rdata_n   = f_rdata;
    d_rdata_n   = d_rdata;
    pick_d      = d_req && (!f_req || !last_d);
    sel_addr    = pick_d ? d_addr  : f_addr;
    sel_wdata   = pick_d ? d_wdata : 32'd0;
    sel_type    = pick_d ? d_type  : 1'b0;
    sel_size    = pick_d ? d_size  : 2'd2;
    rd_val      = mem_type ? 32'd0 : mask_rd(mem_size, mem_rdata);

    unique case (state)
      IDLE: begin
        if (f_req || d_req) begin
          gnt_d_n     = pick_d;
          last_d_n    = pick_d;
          mem_addr_n  = sel_addr;
          mem_wdata_n = sel_wdata;
          mem_type_n  = sel_type;
          mem_size_n  = sel_size;
          if (is_bad(sel_size, sel_addr[1:0])) begin
            state_n = DONE;
            err_n   = 1'b1;
            if (pick_d) d_rdata_n = 32'd0;
            else        f_rdata_n = 32'd0;
          end else begin
            state_n   = WAIT;
            mem_req_n = 1'b1;
            cnt_n     = '0;
          end
        end
      end
      WAIT: begin
        if (mem_ack) begin
          state_n   = DONE;
          mem_req_n = 1'b0;
          err_n     = 1'b0;
          if (gnt_d) d_rdata_n = rd_val;
          else       f_rdata_n = rd_val;
        end else if (cnt == TO_LAST) begin
          state_n   = DONE;
          mem_req_n = 1'b0;
          err_n     = 1'b1;
          if (gnt_d) d_rdata_n = 32'd0;
          else       f_rdata_n = 32'd0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers; reset leaves fetch as last grant so data wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt_d     <= 1'b0;
      last_d    <= 1'b0;
      cnt       <= '0;
      err_q     <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_type  <= 1'b0;
      mem_size  <= 2'd0;
      f_rdata   <= 32'd0;
      d_rdata   <= 32'd0;
    end else begin
      state     <= state_n;
      gnt_d     <= gnt_d_n;
      last_d    <= last_d_n;
      cnt       <= cnt_n;
      err_q     <= err_n;
      mem_req   <= mem_req_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      mem_type  <= mem_type_n;
      mem_size  <= mem_size_n;
      f_rdata   <= f_rdata_n;
      d_rdata   <= d_rdata_n;
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a 4-cycle memory timeout.
module tb_mem_access_arbiter;

  logic        clk;
  logic        rst_n;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_ack;
  logic        f_err;
  logic [31:0] f_rdata;
  logic        d_req;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_type;
  logic [1:0]  d_size;
  logic        d_ack;
  logic        d_err;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_type;
  logic [1:0]  mem_size;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fails  = 0;
  logic [0:0] exp_q[$];

  mem_access_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_err(f_err), .f_rdata(f_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_type(d_type), .d_size(d_size),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_type(mem_type), .mem_size(mem_size), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    f_req = 0; f_addr = 0; d_req = 0; d_addr = 0; d_wdata = 0;
    d_type = 0; d_size = 0; mem_ack = 0; mem_rdata = 0;
  endtask

  // Leaves the bench 1 time unit after a posedge with reset released.
  task automatic reset_dut();
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One data-port transaction; lat counts falling edges from drive to ack.
  task automatic data_xfer(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic typ, input logic [1:0] sz, input logic ack_now,
                           input logic [31:0] mdata, input logic [31:0] exp_rdata,
                           input logic exp_err, input int exp_lat, input int exp_nreq);
    int n;
    int nreq;
    logic seen;
    d_addr = addr; d_wdata = wdata; d_type = typ; d_size = sz; d_req = 1'b1;
    mem_ack = ack_now; mem_rdata = mdata;
    n = 0; nreq = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (d_ack) seen = 1'b1;
      else if (mem_req) begin
        if (nreq == 0) begin
          check({tag, " mem_addr"},  mem_addr,  addr);
          check({tag, " mem_wdata"}, mem_wdata, wdata);
          check({tag, " mem_type"},  {31'd0, mem_type}, {31'd0, typ});
          check({tag, " mem_size"},  {30'd0, mem_size}, {30'd0, sz});
        end
        nreq++;
      end
    end
    check({tag, " ack_seen"}, {31'd0, seen}, 32'd1);
    check({tag, " latency"},  n, exp_lat);
    check({tag, " mem_req_cycles"}, nreq, exp_nreq);
    check({tag, " d_err"},    {31'd0, d_err}, {31'd0, exp_err});
    check({tag, " d_rdata"},  d_rdata, exp_rdata);
    check({tag, " f_ack"},    {31'd0, f_ack}, 32'd0);
    check({tag, " mem_req_done"}, {31'd0, mem_req}, 32'd0);
    @(posedge clk);
    #1 d_req = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    check({tag, " d_ack_drop"}, {31'd0, d_ack}, 32'd0);
    check({tag, " d_rdata_hold"}, d_rdata, exp_rdata);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acks;
    logic got;
    // Reset state
    rst_n = 1'b0;
    drive_idle();
    #1;
    check("rst mem_req", {31'd0, mem_req}, 32'd0);
    check("rst f_ack",   {31'd0, f_ack}, 32'd0);
    check("rst d_ack",   {31'd0, d_ack}, 32'd0);
    check("rst f_rdata", f_rdata, 32'd0);
    check("rst d_rdata", d_rdata, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst state",   {30'd0, dbg_state}, 32'd0);
    reset_dut();

    // Minimum-latency fetch, memory acks in the first mem_req cycle
    f_req = 1'b1; f_addr = 32'h100; mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("fetch c0 mem_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    check("fetch c1 mem_req", {31'd0, mem_req}, 32'd1);
    check("fetch c1 mem_addr", mem_addr, 32'h100);
    check("fetch c1 mem_size", {30'd0, mem_size}, 32'd2);
    check("fetch c1 f_ack",   {31'd0, f_ack}, 32'd0);
    @(negedge clk);
    check("fetch c2 f_ack",   {31'd0, f_ack}, 32'd1);
    check("fetch c2 f_err",   {31'd0, f_err}, 32'd0);
    check("fetch c2 f_rdata", f_rdata, 32'hDEADBEEF);
    check("fetch c2 d_ack",   {31'd0, d_ack}, 32'd0);
    check("fetch c2 mem_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk);
    #1 f_req = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    check("fetch f_ack_drop", {31'd0, f_ack}, 32'd0);
    check("fetch f_rdata_hold", f_rdata, 32'hDEADBEEF);

    // Both requesters held after reset: grants alternate D, F, D, F
    reset_dut();
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    f_req = 1'b1; f_addr = 32'h300;
    d_req = 1'b1; d_addr = 32'h200; d_type = 1'b0; d_size = 2'd2;
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    acks = 0;
    for (int c = 0; c < 40 && acks < 4; c++) begin
      @(negedge clk);
      if (f_ack || d_ack) begin
        check("arb one_ack", {31'd0, f_ack} + {31'd0, d_ack}, 32'd1);
        check("arb order", {31'd0, d_ack}, {31'd0, exp_q.pop_front()});
        check("arb rdata", d_ack ? d_rdata : f_rdata, 32'h12345678);
        acks++;
      end
    end
    check("arb ack_count", acks, 4);
    @(posedge clk);
    #1 drive_idle();
    @(posedge clk);
    #1;

    // Data transfers: sizes, write, misaligned/invalid, timeout
    data_xfer("rd8",   32'h3,   32'h0,        1'b0, 2'd0, 1'b1, 32'h112233AA, 32'h000000AA, 1'b0, 3, 1);
    data_xfer("rd16",  32'h2,   32'h0,        1'b0, 2'd1, 1'b1, 32'h1122BBCC, 32'h0000BBCC, 1'b0, 3, 1);
    data_xfer("rd32",  32'h8,   32'h0,        1'b0, 2'd2, 1'b1, 32'h01020304, 32'h01020304, 1'b0, 3, 1);
    data_xfer("wr32",  32'h40,  32'hCAFEF00D, 1'b1, 2'd2, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b0, 3, 1);
    data_xfer("mis32", 32'h102, 32'h0,        1'b0, 2'd2, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b1, 2, 0);
    data_xfer("mis16", 32'h101, 32'h0,        1'b0, 2'd1, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b1, 2, 0);
    data_xfer("inv3",  32'h0,   32'h0,        1'b0, 2'd3, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b1, 2, 0);
    data_xfer("tmo",   32'h80,  32'h0BADF00D, 1'b1, 2'd2, 1'b0, 32'hFFFFFFFF, 32'h0,        1'b1, 6, 4);

    // Late mem_ack while idle must be ignored
    mem_ack = 1'b1; mem_rdata = 32'h55555555;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("late_ack d_ack", {31'd0, d_ack}, 32'd0);
      check("late_ack mem_req", {31'd0, mem_req}, 32'd0);
    end
    @(posedge clk);
    #1 mem_ack = 1'b0;

    // Reset in the middle of WAIT
    d_addr = 32'h10; d_size = 2'd2; d_type = 1'b0; d_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rstwait pre mem_req", {31'd0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstwait mem_req",  {31'd0, mem_req}, 32'd0);
    check("rstwait mem_addr", mem_addr, 32'd0);
    check("rstwait state",    {30'd0, dbg_state}, 32'd0);
    check("rstwait d_ack",    {31'd0, d_ack}, 32'd0);
    d_req = 1'b0;
    @(negedge clk);
    check("rstwait hold d_ack", {31'd0, d_ack}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    d_req = 1'b1; d_addr = 32'h20; f_req = 1'b1; f_addr = 32'h400;
    mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (f_ack || d_ack) begin
        got = 1'b1;
        check("postrst first d_ack", {31'd0, d_ack}, 32'd1);
        check("postrst first f_ack", {31'd0, f_ack}, 32'd0);
        check("postrst d_rdata", d_rdata, 32'hA5A5A5A5);
      end
    end
    check("postrst ack_seen", {31'd0, got}, 32'd1);
    @(posedge clk);
    #1 d_req = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (f_ack || d_ack) begin
        got = 1'b1;
        check("postrst second f_ack", {31'd0, f_ack}, 32'd1);
      end
    end
    check("postrst second seen", {31'd0, got}, 32'd1);
    @(posedge clk);
    #1 drive_idle();
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
